// File: rtl/seq_checker_04723_if.sv
// Symbol-stream link between a repeating-sequence source and the checker.
// The master drives the stream; the slave (checker) returns lock and error status.
interface seq_checker_04723_if #(
  parameter int CNT_W = 8
);
  logic             valid;
  logic [2:0]       sym;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic [2:0]       exp_sym;
  logic [CNT_W-1:0] lap_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output valid, sym, clr_err,
    input  locked, err, exp_sym, lap_count, err_count
  );

  modport slave (
    input  valid, sym, clr_err,
    output locked, err, exp_sym, lap_count, err_count
  );
endinterface

// File: rtl/seq_checker_04723.sv
// Lock-and-track checker for the repeating 3-bit cycle 0->4->7->2->3->0.
// The flywheel keeps advancing through isolated corruption and drops lock after MISS_MAX misses in a row.
module seq_checker_04723 #(
  parameter int LOCK_N   = 3,
  parameter int MISS_MAX = 2,
  parameter int CNT_W    = 8
) (
  input logic                clk,
  input logic                reset,
  seq_checker_04723_if.slave bus
);

  localparam int MW = (LOCK_N   < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam int XW = (MISS_MAX < 1) ? 1 : $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q;
  logic             locked_q;
  logic             err_q;
  logic [2:0]       exp_sym_q;
  logic [CNT_W-1:0] lap_count_q;
  logic [CNT_W-1:0] err_count_q;
  logic [MW-1:0]    match_cnt_q;
  logic [XW-1:0]    miss_cnt_q;

  function automatic logic [2:0] succ(input logic [2:0] s);
    case (s)
      3'd0:    succ = 3'd4;
      3'd4:    succ = 3'd7;
      3'd7:    succ = 3'd2;
      3'd2:    succ = 3'd3;
      3'd3:    succ = 3'd0;
      default: succ = 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] s);
    is_legal = (s == 3'd0) || (s == 3'd2) || (s == 3'd3) ||
               (s == 3'd4) || (s == 3'd7);
  endfunction

  // NOTE: all state lives in one clocked block assigned with <= only, so every
  // read below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      exp_sym_q   <= 3'd0;
      lap_count_q <= '0;
      err_count_q <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      // NOTE: err is a pulse, so it defaults low every edge and only the
      // locked-mismatch branch raises it.
      err_q <= 1'b0;
      if (bus.clr_err) err_count_q <= '0;

      if (bus.valid) begin
        case (state_q)
          HUNT: begin
            if (is_legal(bus.sym)) begin
              state_q     <= VERIFY;
              exp_sym_q   <= succ(bus.sym);
              match_cnt_q <= '0;
            end
          end

          VERIFY: begin
            if (bus.sym == exp_sym_q) begin
              match_cnt_q <= match_cnt_q + MW'(1);
              exp_sym_q   <= succ(exp_sym_q);
              if (match_cnt_q + MW'(1) == MW'(LOCK_N)) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else if (is_legal(bus.sym)) begin
              exp_sym_q   <= succ(bus.sym);
              match_cnt_q <= '0;
            end else begin
              state_q     <= HUNT;
              exp_sym_q   <= 3'd0;
              match_cnt_q <= '0;
            end
          end

          LOCKED: begin
            if (bus.sym == exp_sym_q) begin
              miss_cnt_q <= '0;
              exp_sym_q  <= succ(exp_sym_q);
              if (bus.sym == 3'd3) lap_count_q <= lap_count_q + CNT_W'(1);
            end else begin
              err_q <= 1'b1;
              // A clear on the same edge still counts the new error.
              if (bus.clr_err)
                err_count_q <= CNT_W'(1);
              else if (err_count_q != '1)
                err_count_q <= err_count_q + CNT_W'(1);

              if (miss_cnt_q + XW'(1) == XW'(MISS_MAX)) begin
                state_q     <= HUNT;
                locked_q    <= 1'b0;
                exp_sym_q   <= 3'd0;
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
              end else begin
                miss_cnt_q <= miss_cnt_q + XW'(1);
                exp_sym_q  <= succ(exp_sym_q);
              end
            end
          end

          default: begin
            state_q   <= HUNT;
            locked_q  <= 1'b0;
            exp_sym_q <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.exp_sym   = exp_sym_q;
  assign bus.lap_count = lap_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_seq_checker_04723.sv
// Randomized scoreboard bench for seq_checker_04723: directed scenarios followed by
// a corrupted random stream, each cycle's expected outputs queued from a sequence-position model.
module tb_seq_checker_04723;

  localparam int LOCK_N   = 3;
  localparam int MISS_MAX = 2;
  localparam int CNT_W    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_checker_04723_if #(.CNT_W(CNT_W)) bus ();

  seq_checker_04723 #(.LOCK_N(LOCK_N), .MISS_MAX(MISS_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       locked;
    logic       err;
    logic [2:0] exp_sym;
    int         lap;
    int         ec;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the cycle is an array and the tracker is a position in it.
  int seq_tab [5] = '{0, 4, 7, 2, 3};
  int m_mode;  // 0 hunt, 1 verify, 2 locked
  int m_exp, m_mc, m_miss, m_lap, m_ec;
  bit m_err;
  int g;       // generator position for the stimulus stream

  function automatic int pos_of(int s);
    for (int i = 0; i < 5; i++) if (seq_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic int next_of(int s);
    return seq_tab[(pos_of(s) + 1) % 5];
  endfunction

  task automatic model_step(bit rst, bit v, int s, bit clr);
    if (rst) begin
      m_mode = 0; m_exp = 0; m_mc = 0; m_miss = 0; m_lap = 0; m_ec = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (clr) m_ec = 0;
    if (!v) return;
    if (m_mode == 0) begin
      if (pos_of(s) >= 0) begin m_mode = 1; m_exp = next_of(s); m_mc = 0; end
    end else if (m_mode == 1) begin
      if (s == m_exp) begin
        m_mc++; m_exp = next_of(m_exp);
        if (m_mc == LOCK_N) begin m_mode = 2; m_miss = 0; end
      end else if (pos_of(s) >= 0) begin
        m_exp = next_of(s); m_mc = 0;
      end else begin
        m_mode = 0; m_exp = 0; m_mc = 0;
      end
    end else begin
      if (s == m_exp) begin
        m_miss = 0;
        if (s == 3) m_lap = (m_lap + 1) % (1 << CNT_W);
        m_exp = next_of(m_exp);
      end else begin
        m_err = 1;
        m_ec  = clr ? 1 : ((m_ec < (1 << CNT_W) - 1) ? m_ec + 1 : m_ec);
        m_miss++;
        m_exp = next_of(m_exp);
        if (m_miss == MISS_MAX) begin m_mode = 0; m_exp = 0; m_mc = 0; m_miss = 0; end
      end
    end
  endtask

  // Drive one cycle on the falling edge and queue what the next rising edge should produce.
  task automatic step(int s, bit v = 1'b1, bit clr = 1'b0, bit rst = 1'b0);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    bus.valid   = v;
    bus.sym     = 3'(s);
    bus.clr_err = clr;
    model_step(rst, v, s, clr);
    e.locked  = (m_mode == 2);
    e.err     = m_err;
    e.exp_sym = 3'(m_exp);
    e.lap     = m_lap;
    e.ec      = m_ec;
    sb_q.push_back(e);
  endtask

  task automatic good(int n);
    for (int i = 0; i < n; i++) begin
      step(seq_tab[g]);
      g = (g + 1) % 5;
    end
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("locked",    int'(bus.locked),    int'(e.locked));
        chk("err",       int'(bus.err),       int'(e.err));
        chk("exp_sym",   int'(bus.exp_sym),   int'(e.exp_sym));
        chk("lap_count", int'(bus.lap_count), e.lap);
        chk("err_count", int'(bus.err_count), e.ec);
      end
    end
  end

  initial begin
    reset = 1'b1; bus.valid = 1'b0; bus.sym = 3'd0; bus.clr_err = 1'b0;
    m_mode = 0; m_exp = 0; m_mc = 0; m_miss = 0; m_lap = 0; m_ec = 0; m_err = 0;
    g = 0;

    // Reset state, then acquire lock on 0,4,7,2 and complete a lap on 3.
    step(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0, 1'b1);
    good(5);

    // Ten laps with valid toggling; invalid cycles carry garbage that must be ignored.
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) begin
        step(seq_tab[g]); g = (g + 1) % 5;
      end else begin
        step(int'($urandom_range(7)), 1'b0);
      end
    end

    // Single corruption while expecting 7, then resume.
    while (seq_tab[g] != 7) good(1);
    step(5); g = (g + 1) % 5;
    good(3);

    // Two consecutive misses drop lock; re-lock needs seed plus LOCK_N matches.
    step(1); g = (g + 1) % 5;
    step(6); g = (g + 1) % 5;
    good(4);
    good(2);

    // HUNT ignores illegal symbols; legal ones seed and re-seed without err.
    step(5); step(6); step(5);   // drive the checker back to HUNT
    step(1); step(6); step(7); step(4);
    step(6);                     // back to HUNT
    g = 0;
    good(4);

    // Saturate err_count with isolated errors, then one more error at the ceiling.
    for (int i = 0; i < 258; i++) begin
      step(1); g = (g + 1) % 5;
      good(1);
    end
    // Clear on the same edge as a mismatch, then a clear with valid low.
    step(1, 1'b1, 1'b1); g = (g + 1) % 5;
    good(1);
    step(0, 1'b0, 1'b1);

    // Reset in the middle of VERIFY.
    step(6); step(6);
    step(0); step(4);
    step(3, 1'b1, 1'b0, 1'b1);
    step(0, 1'b0);

    // Randomized stream: mostly correct, with corruption, slips, gaps, clears and resets.
    g = 0;
    for (int i = 0; i < 3000; i++) begin
      int  r = int'($urandom_range(99));
      bit  v = ($urandom_range(4) != 0);
      bit  c = ($urandom_range(49) == 0);
      bit  rs = ($urandom_range(299) == 0);
      int  s = seq_tab[g];
      if (r >= 85 && r < 95) s = int'($urandom_range(7));
      if (v) g = (g + ((r >= 95) ? 2 : 1)) % 5;
      step(s, v, c, rs);
    end

    step(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
